// File: rtl/mem_arbiter_pkg.sv
// Shared types for the unified-RAM arbiter: size codes, FSM states, owner flag.
package mem_arbiter_pkg;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  typedef enum logic [1:0] {StIdle, StRd, StWr, StDone} state_e;
  typedef enum logic {OwnIf, OwnMem} owner_e;

  // Reserved size code 3 is treated as a word.
  function automatic logic [2:0] size_to_len(input logic [1:0] size);
    case (size)
      SIZE_B:  return 3'd1;
      SIZE_H:  return 3'd2;
      SIZE_W:  return 3'd4;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the byte-wide RAM port between fetch and load/store, serialising
// 1/2/4-byte accesses and assembling read data little-endian.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned RAM_ADDR_W = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  if_req,
  input  logic [ADDR_W-1:0]     if_addr,
  input  logic                  if_flush,
  output logic [31:0]           if_data,
  output logic                  if_done,
  input  logic                  mem_req,
  input  logic                  mem_wr,
  input  logic [1:0]            mem_size,
  input  logic [ADDR_W-1:0]     mem_addr,
  input  logic [31:0]           mem_wdata,
  output logic [31:0]           mem_rdata,
  output logic                  mem_done,
  output logic [RAM_ADDR_W-1:0] ram_a,
  output logic                  ram_wr,
  output logic [7:0]            ram_din,
  input  logic [7:0]            ram_dout
);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [2:0]        len_q, len_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       asm_q, asm_d;
  logic [31:0]       if_data_q, if_data_d;
  logic [31:0]       mem_rdata_q, mem_rdata_d;
  logic              if_done_q, if_done_d;
  logic              mem_done_q, mem_done_d;

  logic [1:0]        cap_idx;
  logic [2:0]        rd_idx;
  logic [ADDR_W-1:0] addr_full;
  logic              unused_addr_hi;

  assign cap_idx = 2'(cnt_q - 3'd1);

  // While stalled in RD, re-present the address of the byte still awaiting
  // capture so ram_dout carries that byte when rdy returns.
  always_comb begin
    rd_idx = cnt_q;
    if (state_q == StRd && !rdy && cnt_q != 3'd0) rd_idx = cnt_q - 3'd1;
  end

  assign addr_full      = base_q + ADDR_W'(rd_idx);
  assign unused_addr_hi = ^addr_full[ADDR_W-1:RAM_ADDR_W];

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    base_d      = base_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    wdata_d     = wdata_q;
    asm_d       = asm_q;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;
    if_done_d   = if_done_q;
    mem_done_d  = mem_done_q;
    if (rdy) begin
      if_done_d  = 1'b0;
      mem_done_d = 1'b0;
      unique case (state_q)
        // The edge ending DONE arbitrates exactly like IDLE.
        StIdle, StDone: begin
          state_d = StIdle;
          if (mem_req) begin
            owner_d = OwnMem;
            base_d  = mem_addr;
            len_d   = size_to_len(mem_size);
            wdata_d = mem_wdata;
            cnt_d   = 3'd0;
            asm_d   = 32'h0;
            state_d = mem_wr ? StWr : StRd;
          end else if (if_req && !if_flush) begin
            owner_d = OwnIf;
            base_d  = if_addr;
            len_d   = 3'd4;
            cnt_d   = 3'd0;
            asm_d   = 32'h0;
            state_d = StRd;
          end
        end
        StRd: begin
          if (owner_q == OwnIf && if_flush) begin
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q + 3'd1;
            if (cnt_q != 3'd0) asm_d[{cap_idx, 3'b000} +: 8] = ram_dout;
            if (cnt_q == len_q) begin
              state_d = StDone;
              if (owner_q == OwnIf) begin
                if_data_d = asm_d;
                if_done_d = 1'b1;
              end else begin
                mem_rdata_d = asm_d;
                mem_done_d  = 1'b1;
              end
            end
          end
        end
        StWr: begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == len_q - 3'd1) begin
            state_d    = StDone;
            mem_done_d = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      owner_q     <= OwnIf;
      base_q      <= '0;
      len_q       <= 3'd0;
      cnt_q       <= 3'd0;
      wdata_q     <= 32'h0;
      asm_q       <= 32'h0;
      if_data_q   <= 32'h0;
      mem_rdata_q <= 32'h0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      base_q      <= base_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      wdata_q     <= wdata_d;
      asm_q       <= asm_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
    end
  end

  always_comb begin
    ram_a   = '0;
    ram_wr  = 1'b0;
    ram_din = 8'h00;
    if (state_q == StRd || state_q == StWr) ram_a = addr_full[RAM_ADDR_W-1:0];
    if (state_q == StWr) begin
      ram_wr  = rdy;
      ram_din = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
    end
  end

  assign if_data   = if_data_q;
  assign if_done   = if_done_q;
  assign mem_rdata = mem_rdata_q;
  assign mem_done  = mem_done_q;

endmodule
